// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants and control-bundle types for the ID/EX, EX/MEM and MEM/WB registers.
package riscv_pipe_pkg;

    localparam int XLEN        = 32;
    localparam int ALUOP_W     = 4;
    localparam int REG_ADDR_W  = 5;
    localparam int FUNCT3_W    = 3;
    localparam int CTRL_FLAG_W = 7;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
        logic jump;
    } ctrl_flags_t;

    // All-zero control word: a NOP bubble that writes nothing and never branches.
    localparam ctrl_flags_t CTRL_BUBBLE = ctrl_flags_t'({CTRL_FLAG_W{1'b0}});

endpackage

// File: rtl/idex_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of a load sitting in EX.
module idex_hazard_detect
    import riscv_pipe_pkg::*;
(
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    output logic                  hazard
);

    logic rs1_match_s;
    logic rs2_match_s;

    assign rs1_match_s = id_rs1_used & (ex_rd_addr == id_rs1_addr);
    assign rs2_match_s = id_rs2_used & (ex_rd_addr == id_rs2_addr);

    // x0 is never a real destination, so a load to x0 cannot create a dependency.
    assign hazard = ex_valid & ex_mem_read & (ex_rd_addr != {REG_ADDR_W{1'b0}})
                  & (rs1_match_s | rs2_match_s);

endmodule

// File: rtl/idex_pipeline_reg.sv
// ID/EX pipeline register with stall, flush and bubble insertion.
// Define IDEX_LOADUSE_DETECT_EN to build in load-use detection and the IF/ID stall request.
module idex_pipeline_reg #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid_ID,
    input  logic [XLEN-1:0]    i_pc_ID,
    input  logic [XLEN-1:0]    i_rs1_data_ID,
    input  logic [XLEN-1:0]    i_rs2_data_ID,
    input  logic [XLEN-1:0]    i_imm_ID,
    input  logic [4:0]         i_rs1_addr_ID,
    input  logic [4:0]         i_rs2_addr_ID,
    input  logic [4:0]         i_rd_addr_ID,
    input  logic               i_rs1_used_ID,
    input  logic               i_rs2_used_ID,
    input  logic [2:0]         i_funct3_ID,
    input  logic               i_clu_RegWrite_ID,
    input  logic               i_clu_MemRead_ID,
    input  logic               i_clu_MemWrite_ID,
    input  logic               i_clu_MemtoReg_ID,
    input  logic               i_clu_ALUSrc_ID,
    input  logic               i_clu_Branch_ID,
    input  logic               i_clu_Jump_ID,
    input  logic [ALUOP_W-1:0] i_clu_ALUOp_ID,
    output logic               o_valid_IDEX,
    output logic [XLEN-1:0]    o_pc_IDEX,
    output logic [XLEN-1:0]    o_rs1_data_IDEX,
    output logic [XLEN-1:0]    o_rs2_data_IDEX,
    output logic [XLEN-1:0]    o_imm_IDEX,
    output logic [4:0]         o_rs1_addr_IDEX,
    output logic [4:0]         o_rs2_addr_IDEX,
    output logic [4:0]         o_rd_addr_IDEX,
    output logic [2:0]         o_funct3_IDEX,
    output logic               o_clu_RegWrite_IDEX,
    output logic               o_clu_MemRead_IDEX,
    output logic               o_clu_MemWrite_IDEX,
    output logic               o_clu_MemtoReg_IDEX,
    output logic               o_clu_ALUSrc_IDEX,
    output logic               o_clu_Branch_IDEX,
    output logic               o_clu_Jump_IDEX,
    output logic [ALUOP_W-1:0] o_clu_ALUOp_IDEX,
    output logic               o_stall_IFID
);

    import riscv_pipe_pkg::*;

    logic                  valid_r;
    logic [XLEN-1:0]       pc_r;
    logic [XLEN-1:0]       rs1_data_r;
    logic [XLEN-1:0]       rs2_data_r;
    logic [XLEN-1:0]       imm_r;
    logic [REG_ADDR_W-1:0] rs1_addr_r;
    logic [REG_ADDR_W-1:0] rs2_addr_r;
    logic [REG_ADDR_W-1:0] rd_addr_r;
    logic [FUNCT3_W-1:0]   funct3_r;
    ctrl_flags_t           ctrl_r;
    logic [ALUOP_W-1:0]    alu_op_r;

    ctrl_flags_t ctrl_id_s;
    logic        hazard_s;
    logic        hold_s;
    logic        bubble_s;

    assign ctrl_id_s = '{reg_write:  i_clu_RegWrite_ID,
                         mem_read:   i_clu_MemRead_ID,
                         mem_write:  i_clu_MemWrite_ID,
                         mem_to_reg: i_clu_MemtoReg_ID,
                         alu_src:    i_clu_ALUSrc_ID,
                         branch:     i_clu_Branch_ID,
                         jump:       i_clu_Jump_ID};

`ifdef IDEX_LOADUSE_DETECT_EN
    idex_hazard_detect u_hazard (
        .ex_valid    (valid_r),
        .ex_mem_read (ctrl_r.mem_read),
        .ex_rd_addr  (rd_addr_r),
        .id_rs1_addr (i_rs1_addr_ID),
        .id_rs2_addr (i_rs2_addr_ID),
        .id_rs1_used (i_rs1_used_ID),
        .id_rs2_used (i_rs2_used_ID),
        .hazard      (hazard_s)
    );
`else
    assign hazard_s = 1'b0;
`endif

    assign o_stall_IFID = hazard_s & ~i_flush;

    // Edge priority: flush beats stall, stall beats hazard bubble, bubble beats load.
    always_comb begin
        hold_s   = 1'b0;
        bubble_s = 1'b0;
        if (i_flush) begin
            bubble_s = 1'b1;
        end else if (i_stall) begin
            hold_s = 1'b1;
        end else begin
            bubble_s = hazard_s | ~i_valid_ID;
        end
    end

    // Pipeline state: a bubble zeroes every field so forwarding never matches a stale address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r    <= 1'b0;
            pc_r       <= {XLEN{1'b0}};
            rs1_data_r <= {XLEN{1'b0}};
            rs2_data_r <= {XLEN{1'b0}};
            imm_r      <= {XLEN{1'b0}};
            rs1_addr_r <= {REG_ADDR_W{1'b0}};
            rs2_addr_r <= {REG_ADDR_W{1'b0}};
            rd_addr_r  <= {REG_ADDR_W{1'b0}};
            funct3_r   <= {FUNCT3_W{1'b0}};
            ctrl_r     <= CTRL_BUBBLE;
            alu_op_r   <= {ALUOP_W{1'b0}};
        end else if (hold_s) begin
            valid_r    <= valid_r;
            pc_r       <= pc_r;
            rs1_data_r <= rs1_data_r;
            rs2_data_r <= rs2_data_r;
            imm_r      <= imm_r;
            rs1_addr_r <= rs1_addr_r;
            rs2_addr_r <= rs2_addr_r;
            rd_addr_r  <= rd_addr_r;
            funct3_r   <= funct3_r;
            ctrl_r     <= ctrl_r;
            alu_op_r   <= alu_op_r;
        end else if (bubble_s) begin
            valid_r    <= 1'b0;
            pc_r       <= {XLEN{1'b0}};
            rs1_data_r <= {XLEN{1'b0}};
            rs2_data_r <= {XLEN{1'b0}};
            imm_r      <= {XLEN{1'b0}};
            rs1_addr_r <= {REG_ADDR_W{1'b0}};
            rs2_addr_r <= {REG_ADDR_W{1'b0}};
            rd_addr_r  <= {REG_ADDR_W{1'b0}};
            funct3_r   <= {FUNCT3_W{1'b0}};
            ctrl_r     <= CTRL_BUBBLE;
            alu_op_r   <= {ALUOP_W{1'b0}};
        end else begin
            valid_r    <= 1'b1;
            pc_r       <= i_pc_ID;
            rs1_data_r <= i_rs1_data_ID;
            rs2_data_r <= i_rs2_data_ID;
            imm_r      <= i_imm_ID;
            rs1_addr_r <= i_rs1_addr_ID;
            rs2_addr_r <= i_rs2_addr_ID;
            rd_addr_r  <= i_rd_addr_ID;
            funct3_r   <= i_funct3_ID;
            ctrl_r     <= ctrl_id_s;
            alu_op_r   <= i_clu_ALUOp_ID;
        end
    end

    assign o_valid_IDEX        = valid_r;
    assign o_pc_IDEX           = pc_r;
    assign o_rs1_data_IDEX     = rs1_data_r;
    assign o_rs2_data_IDEX     = rs2_data_r;
    assign o_imm_IDEX          = imm_r;
    assign o_rs1_addr_IDEX     = rs1_addr_r;
    assign o_rs2_addr_IDEX     = rs2_addr_r;
    assign o_rd_addr_IDEX      = rd_addr_r;
    assign o_funct3_IDEX       = funct3_r;
    assign o_clu_RegWrite_IDEX = ctrl_r.reg_write;
    assign o_clu_MemRead_IDEX  = ctrl_r.mem_read;
    assign o_clu_MemWrite_IDEX = ctrl_r.mem_write;
    assign o_clu_MemtoReg_IDEX = ctrl_r.mem_to_reg;
    assign o_clu_ALUSrc_IDEX   = ctrl_r.alu_src;
    assign o_clu_Branch_IDEX   = ctrl_r.branch;
    assign o_clu_Jump_IDEX     = ctrl_r.jump;
    assign o_clu_ALUOp_IDEX    = alu_op_r;

endmodule
